// File: rtl/de_mux4.sv
// Registered byte steering for the UART block: 1:4 demux, 4:1 mux and 8:1 mux, all independent.
// One-cycle latency on every path. There is no backpressure, so every output flop is rewritten on every clock edge.
module de_mux4 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic [1:0]            demux_select,
  input  logic [DATA_WIDTH-1:0] demux_data_i,
  output logic [DATA_WIDTH-1:0] demux_data0_o,
  output logic [DATA_WIDTH-1:0] demux_data1_o,
  output logic [DATA_WIDTH-1:0] demux_data2_o,
  output logic [DATA_WIDTH-1:0] demux_data3_o,

  input  logic [1:0]            mux4_select_i,
  input  logic [DATA_WIDTH-1:0] mux4_data0_i,
  input  logic [DATA_WIDTH-1:0] mux4_data1_i,
  input  logic [DATA_WIDTH-1:0] mux4_data2_i,
  input  logic [DATA_WIDTH-1:0] mux4_data3_i,
  output logic [DATA_WIDTH-1:0] mux4_data_o,

  input  logic [2:0]            mux8_select_i,
  input  logic [DATA_WIDTH-1:0] mux8_data0_i,
  input  logic [DATA_WIDTH-1:0] mux8_data1_i,
  input  logic [DATA_WIDTH-1:0] mux8_data2_i,
  input  logic [DATA_WIDTH-1:0] mux8_data3_i,
  input  logic [DATA_WIDTH-1:0] mux8_data4_i,
  input  logic [DATA_WIDTH-1:0] mux8_data5_i,
  input  logic [DATA_WIDTH-1:0] mux8_data6_i,
  input  logic [DATA_WIDTH-1:0] mux8_data7_i,
  output logic [DATA_WIDTH-1:0] mux8_data_o
);

  logic [DATA_WIDTH-1:0] mux4_nxt;
  logic [DATA_WIDTH-1:0] mux8_nxt;

  always_comb begin
    mux4_nxt = mux4_data0_i;
    case (mux4_select_i)
      2'd0: mux4_nxt = mux4_data0_i;
      2'd1: mux4_nxt = mux4_data1_i;
      2'd2: mux4_nxt = mux4_data2_i;
      2'd3: mux4_nxt = mux4_data3_i;
      default: mux4_nxt = mux4_data0_i;
    endcase
  end

  always_comb begin
    mux8_nxt = mux8_data0_i;
    case (mux8_select_i)
      3'd0: mux8_nxt = mux8_data0_i;
      3'd1: mux8_nxt = mux8_data1_i;
      3'd2: mux8_nxt = mux8_data2_i;
      3'd3: mux8_nxt = mux8_data3_i;
      3'd4: mux8_nxt = mux8_data4_i;
      3'd5: mux8_nxt = mux8_data5_i;
      3'd6: mux8_nxt = mux8_data6_i;
      3'd7: mux8_nxt = mux8_data7_i;
      default: mux8_nxt = mux8_data0_i;
    endcase
  end

  // Unselected demux outputs are forced to zero so at most one is ever non-zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      demux_data0_o <= '0;
      demux_data1_o <= '0;
      demux_data2_o <= '0;
      demux_data3_o <= '0;
      mux4_data_o   <= '0;
      mux8_data_o   <= '0;
    end else begin
      demux_data0_o <= (demux_select == 2'd0) ? demux_data_i : '0;
      demux_data1_o <= (demux_select == 2'd1) ? demux_data_i : '0;
      demux_data2_o <= (demux_select == 2'd2) ? demux_data_i : '0;
      demux_data3_o <= (demux_select == 2'd3) ? demux_data_i : '0;
      mux4_data_o   <= mux4_nxt;
      mux8_data_o   <= mux8_nxt;
    end
  end

endmodule

// File: tb/tb_de_mux4.sv
// Bench for de_mux4: directed vectors with literal checks plus a per-cycle array-based reference model.
module tb_de_mux4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dm_sel = '0;
  logic [7:0] dm_dat = '0;
  logic [1:0] m4_sel = '0;
  logic [2:0] m8_sel = '0;
  logic [7:0] m4 [4];
  logic [7:0] m8 [8];
  logic [7:0] d_o [4];
  logic [7:0] m4_o, m8_o;

  logic [7:0] exp_d [4];
  logic [7:0] exp_m4, exp_m8;
  logic       model_on = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  de_mux4 #(.DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .demux_select(dm_sel), .demux_data_i(dm_dat),
    .demux_data0_o(d_o[0]), .demux_data1_o(d_o[1]),
    .demux_data2_o(d_o[2]), .demux_data3_o(d_o[3]),
    .mux4_select_i(m4_sel),
    .mux4_data0_i(m4[0]), .mux4_data1_i(m4[1]),
    .mux4_data2_i(m4[2]), .mux4_data3_i(m4[3]),
    .mux4_data_o(m4_o),
    .mux8_select_i(m8_sel),
    .mux8_data0_i(m8[0]), .mux8_data1_i(m8[1]), .mux8_data2_i(m8[2]), .mux8_data3_i(m8[3]),
    .mux8_data4_i(m8[4]), .mux8_data5_i(m8[5]), .mux8_data6_i(m8[6]), .mux8_data7_i(m8[7]),
    .mux8_data_o(m8_o)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, required %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the registered outputs are simply last edge's routing of input arrays.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) exp_d[k] = 8'h00;
      exp_m4 = 8'h00;
      exp_m8 = 8'h00;
    end else begin
      for (int k = 0; k < 4; k++) exp_d[k] = (int'(dm_sel) == k) ? dm_dat : 8'h00;
      exp_m4 = m4[m4_sel];
      exp_m8 = m8[m8_sel];
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      chk("model_d0", d_o[0], exp_d[0]);
      chk("model_d1", d_o[1], exp_d[1]);
      chk("model_d2", d_o[2], exp_d[2]);
      chk("model_d3", d_o[3], exp_d[3]);
      chk("model_m4", m4_o, exp_m4);
      chk("model_m8", m8_o, exp_m8);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3,
                         input logic [7:0] e4, input logic [7:0] e8);
    chk({nm, "_d0"}, d_o[0], e0);
    chk({nm, "_d1"}, d_o[1], e1);
    chk({nm, "_d2"}, d_o[2], e2);
    chk({nm, "_d3"}, d_o[3], e3);
    chk({nm, "_m4"}, m4_o, e4);
    chk({nm, "_m8"}, m8_o, e8);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) m4[k] = 8'hFF;
    for (int k = 0; k < 8; k++) m8[k] = 8'hFF;
    dm_sel = 2'd3; dm_dat = 8'hFF; m4_sel = 2'd3; m8_sel = 3'd7;
    #2 reset = 1'b0;
    #1 model_on = 1'b1;

    // Held in reset with all inputs high: outputs must stay zero across edges.
    repeat (3) step();
    chk_all("rst_hold", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    reset = 1'b1;
    step();
    chk_all("rst_rel", 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF);

    // Outputs at A5, then async reset between edges.
    dm_sel = 2'd0; dm_dat = 8'hA5; m4_sel = 2'd1; m8_sel = 3'd2;
    for (int k = 0; k < 4; k++) m4[k] = 8'hA5;
    for (int k = 0; k < 8; k++) m8[k] = 8'hA5;
    step();
    chk_all("pre_rst", 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5);
    #2 reset = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    reset = 1'b1;

    // DeMux4 sweep
    dm_dat = 8'h3C;
    for (int s = 0; s < 4; s++) begin
      dm_sel = 2'(s);
      step();
      chk("dm_sweep_d0", d_o[0], (s == 0) ? 8'h3C : 8'h00);
      chk("dm_sweep_d1", d_o[1], (s == 1) ? 8'h3C : 8'h00);
      chk("dm_sweep_d2", d_o[2], (s == 2) ? 8'h3C : 8'h00);
      chk("dm_sweep_d3", d_o[3], (s == 3) ? 8'h3C : 8'h00);
    end

    // Mux4 sweep, descending select
    m4[0] = 8'h11; m4[1] = 8'h22; m4[2] = 8'h33; m4[3] = 8'h44;
    m4_sel = 2'd3; step(); chk("m4_sel3", m4_o, 8'h44);
    m4_sel = 2'd2; chk("m4_latency", m4_o, 8'h44); step(); chk("m4_sel2", m4_o, 8'h33);
    m4_sel = 2'd1; step(); chk("m4_sel1", m4_o, 8'h22);
    m4_sel = 2'd0; step(); chk("m4_sel0", m4_o, 8'h11);

    // Mux8 sweep
    for (int k = 0; k < 8; k++) m8[k] = 8'(k * 16);
    for (int s = 0; s < 8; s++) begin
      m8_sel = 3'(s);
      step();
      chk("m8_sweep", m8_o, 8'(s * 16));
    end
    m8[1] = 8'hC0; m8_sel = 3'd1;
    step();
    chk("m8_c0", m8_o, 8'hC0);

    // Simultaneous select and data change on the demux
    dm_sel = 2'd1; dm_dat = 8'h55;
    step();
    chk("simul_pre_d1", d_o[1], 8'h55);
    dm_sel = 2'd2; dm_dat = 8'hAA;
    step();
    chk_all("simul", 8'h00, 8'h00, 8'hAA, 8'h00, 8'h11, 8'hC0);

    // Only the Mux8 path moves; the other paths must hold their values.
    for (int c = 0; c < 8; c++) begin
      m8_sel = 3'(7 - c);
      m8[7 - c] = 8'(8'h81 + c);
      step();
      chk("indep_m8", m8_o, 8'(8'h81 + c));
      chk("indep_d2", d_o[2], 8'hAA);
      chk("indep_d1", d_o[1], 8'h00);
      chk("indep_m4", m4_o, 8'h11);
    end

    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
